count_seq_checker: RTL
======================

# count_seq_checker

Receive-side checker for the free-running debug count stream. Accepts samples over a valid/ready handshake and verifies each is the previous sample plus one, modulo 2^DW. Reports lock status, a per-error pulse and a saturating error count. Sits at the consuming end of the count link on the same `clk` domain as the generator.

## Interface
- `DW`, 32: sample width; must match the generator's output data width.
- `LOCK_CNT`, 4: consecutive in-sequence samples required to assert lock; range 1..15.
- `ERR_W`, 16: error counter width.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clear` in 1: synchronous pulse; returns checker to IDLE and zeroes counters.
- `s_valid` in 1: sample present.
- `s_ready` out 1: checker can accept; sample taken on `s_valid && s_ready`.
- `s_data` in DW: sample value.
- `locked` out 1: sequence locked.
- `err_pulse` out 1: one-cycle strobe per in-lock mismatch.
- `err_count` out ERR_W: saturating mismatch count.
- `sample_count` out 32: accepted-sample count, wraps.
- `last_bad` out DW: value of most recent mismatching sample.

## Operation
- States: IDLE, ACQUIRE, LOCKED.
- State register `expected` (DW) and `good_cnt` (4 bits) are internal.
- IDLE, on accept:
  - `expected <= s_data+1`, `good_cnt <= 1`.
  - Next state is LOCKED if `LOCK_CNT==1`, else ACQUIRE.
- ACQUIRE, accept with `s_data==expected`:
  - `good_cnt++`, `expected <= s_data+1`.
  - Go to LOCKED when the incremented `good_cnt` equals `LOCK_CNT`.
- ACQUIRE, accept with mismatch:
  - Reseed: `expected <= s_data+1`, `good_cnt <= 1`, stay in ACQUIRE.
  - No error is counted and `err_pulse` does not fire.
- LOCKED, match: `expected <= s_data+1`, stay.
- LOCKED, mismatch:
  - `err_pulse` fires and `err_count` increments, saturating at all-ones.
  - `last_bad <= s_data`, `expected <= s_data+1`, `good_cnt <= 1`.
  - Next state is ACQUIRE, or LOCKED again if `LOCK_CNT==1`.
- Arithmetic: `expected` is computed modulo 2^DW, so all-ones followed by 0 is a match. `sample_count` wraps modulo 2^32.
- No accept (`s_valid` low): all state holds.
- `clear`:
  - Next state IDLE.
  - `err_count`, `sample_count`, `last_bad`, `good_cnt`, `expected` all go to 0.
  - `clear` wins over a same-cycle accept: that sample is discarded and not counted.
- `s_ready`:
  - Registered. Reset value 0.
  - Goes to 1 on the first `clk` edge after `rst_n` deasserts, and stays 1 thereafter.
  - The checker never back-pressures otherwise.

## Timing
- Reset values: `s_ready`=0, `locked`=0, `err_pulse`=0, `err_count`=0, `sample_count`=0, `last_bad`=0; state IDLE.
- All outputs are registered. Effects of an accept on edge N are visible after edge N; there are no combinational paths from inputs to outputs.
- `locked` rises on the edge that accepts the `LOCK_CNT`-th consecutive good sample. It falls on the edge that accepts the mismatching sample, coincident with `err_pulse` high for exactly one cycle.
- Back-to-back mismatches in LOCKED: only the first produces `err_pulse`; later ones occur in ACQUIRE.
- `rst_n` asserted mid-stream: all outputs go to reset values immediately (asynchronously). The first sample after release is treated as a fresh seed.
- Throughput: one sample per cycle sustained.

## Structure
- Shared package `FPGA_skeleton_PKG` holds:
  - `typedef enum logic [1:0] {CHK_IDLE, CHK_ACQUIRE, CHK_LOCKED} chk_state_t`;
  - default constants `CHK_LOCK_CNT=4` and `CHK_ERR_W=16`.
- One natural sub-module, `sat_counter` (parameter width; ports `inc`, `clr`, `q`), used for `err_count`.
- The FSM, `expected`, `good_cnt` and `sample_count` stay in the top body.

## Test plan
- Reset, then stream 0,1,2,3,4 back-to-back, `LOCK_CNT`=4 -> `s_ready`=1 one cycle after release; `locked` rises after 4th accept (value 3); `err_count`=0; `sample_count`=5.
- Locked stream 10,11,12,20,21 -> `err_pulse` one cycle after 20 accepted, `last_bad`=20, `err_count`=1, `locked` low until 4 good samples from 20 (after 23).
- DW=8 stream 0xFD,0xFE,0xFF,0x00,0x01 -> no error, `locked`=1 after 0x00.
- Err saturation, ERR_W=2: force 5 in-lock mismatches (relock between each) -> `err_count` stops at 3, `err_pulse` still fires 5 times.
- `clear` asserted in the same cycle as a valid sample while LOCKED -> next cycle IDLE, `locked`=0, counters 0, that sample not counted.
- `rst_n` pulled low mid-stream with `s_valid` high -> outputs zero asynchronously; after release the stream reseeds and relocks with no error.

Source files
------------

// File: rtl/count_seq_checker_pkg.sv
// Shared types and default constants for the count-stream checker.
package FPGA_skeleton_PKG;

    typedef enum logic [1:0] {
        CHK_IDLE    = 2'd0,
        CHK_ACQUIRE = 2'd1,
        CHK_LOCKED  = 2'd2
    } chk_state_t;

    localparam int CHK_LOCK_CNT = 4;
    localparam int CHK_ERR_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side checker: each accepted sample must be the previous one plus one
// (mod 2^DW); tracks lock, flags in-lock mismatches and counts samples/errors.
module count_seq_checker
    import FPGA_skeleton_PKG::*;
#(
    parameter int DW       = 32,
    parameter int LOCK_CNT = CHK_LOCK_CNT,
    parameter int ERR_W    = CHK_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      sample_count,
    output logic [DW-1:0]    last_bad
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    // A fresh seed already counts as one good sample, so LOCK_CNT==1 locks at once.
    localparam chk_state_t SEED_STATE = (LOCK_CNT == 1) ? CHK_LOCKED : CHK_ACQUIRE;

    chk_state_t    state_q, state_d;
    logic [DW-1:0] expected_q, expected_d;
    logic [3:0]    good_cnt_q, good_cnt_d;
    logic [31:0]   sample_count_q, sample_count_d;
    logic [DW-1:0] last_bad_q, last_bad_d;
    logic          locked_q, locked_d;
    logic          err_pulse_q, err_pulse_d;
    logic          s_ready_q;

    logic          accept_s;
    logic          match_s;
    logic [DW-1:0] data_inc_s;
    logic [3:0]    good_inc_s;

    assign accept_s   = s_valid && s_ready_q;
    assign match_s    = (s_data == expected_q);
    assign data_inc_s = s_data + {{(DW-1){1'b0}}, 1'b1};
    assign good_inc_s = good_cnt_q + 4'd1;

    // Sequence FSM next-state and registered-output next values.
    always_comb begin
        state_d        = state_q;
        expected_d     = expected_q;
        good_cnt_d     = good_cnt_q;
        sample_count_d = sample_count_q;
        last_bad_d     = last_bad_q;
        err_pulse_d    = 1'b0;
        if (clear) begin
            state_d        = CHK_IDLE;
            expected_d     = {DW{1'b0}};
            good_cnt_d     = 4'd0;
            sample_count_d = 32'd0;
            last_bad_d     = {DW{1'b0}};
        end else if (accept_s) begin
            sample_count_d = sample_count_q + 32'd1;
            expected_d     = data_inc_s;
            case (state_q)
                CHK_IDLE: begin
                    good_cnt_d = 4'd1;
                    state_d    = SEED_STATE;
                end
                CHK_ACQUIRE: begin
                    if (match_s) begin
                        good_cnt_d = good_inc_s;
                        state_d    = (good_inc_s == LOCK_N) ? CHK_LOCKED : CHK_ACQUIRE;
                    end else begin
                        good_cnt_d = 4'd1;
                        state_d    = SEED_STATE;
                    end
                end
                CHK_LOCKED: begin
                    if (match_s) begin
                        state_d = CHK_LOCKED;
                    end else begin
                        err_pulse_d = 1'b1;
                        last_bad_d  = s_data;
                        good_cnt_d  = 4'd1;
                        state_d     = SEED_STATE;
                    end
                end
                default: begin
                    good_cnt_d = 4'd0;
                    state_d    = CHK_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == CHK_LOCKED);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= CHK_IDLE;
            expected_q     <= {DW{1'b0}};
            good_cnt_q     <= 4'd0;
            sample_count_q <= 32'd0;
            last_bad_q     <= {DW{1'b0}};
            locked_q       <= 1'b0;
            err_pulse_q    <= 1'b0;
            s_ready_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            expected_q     <= expected_d;
            good_cnt_q     <= good_cnt_d;
            sample_count_q <= sample_count_d;
            last_bad_q     <= last_bad_d;
            locked_q       <= locked_d;
            err_pulse_q    <= err_pulse_d;
            s_ready_q      <= 1'b1;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (err_pulse_d),
        .q     (err_count)
    );

    assign s_ready      = s_ready_q;
    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign sample_count = sample_count_q;
    assign last_bad     = last_bad_q;

endmodule
